// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for the MM:SS stopwatch: prescaled tick enables, counter strobes, clear, blink.
// Optional lap/display-hold feature is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned ADJ_HZ = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  input  logic       sec_at_59,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output logic       sec_inc,
  output logic       min_inc,
  output logic       clr_cnt,
  output logic       blink_sec,
  output logic       blink_min,
  output logic [1:0] state,
  output logic       disp_hold
);

  localparam int unsigned DIV  = CLK_HZ / ADJ_HZ;
  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StPaused = 2'b01,
    StAdjMin = 2'b10,
    StAdjSec = 2'b11
  } state_e;

  state_e            r_state, w_state_d, w_field;
  logic [CntW-1:0]   r_div_cnt, w_div_cnt_d;
  logic              r_phase, w_phase_d;
  logic              r_pause_q, r_clr;
  logic              r_sec_inc, r_min_inc, w_sec_inc_d, w_min_inc_d;
  logic              w_pause_edge, w_in_adj, w_to_adj, w_enter_adj;
  logic              w_ps_run, w_tick_adj, w_tick_1hz;

  assign w_pause_edge = pause & ~r_pause_q;
  assign w_in_adj     = (r_state == StAdjMin) || (r_state == StAdjSec);
  assign w_to_adj     = (w_state_d == StAdjMin) || (w_state_d == StAdjSec);
  assign w_enter_adj  = w_to_adj & ~w_in_adj;

  // adj outranks the pause edge; the edge register still tracks pause meanwhile
  always_comb begin
    w_state_d = r_state;
    if (adj) begin
      w_state_d = sel ? StAdjSec : StAdjMin;
    end else if (w_in_adj) begin
      w_state_d = StPaused;
    end else if (w_pause_edge) begin
      w_state_d = (r_state == StRun) ? StPaused : StRun;
    end
  end

  assign w_ps_run   = (r_state != StPaused) & ~clr;
  assign w_tick_adj = w_ps_run & (r_div_cnt == CntMax);
  assign w_tick_1hz = w_tick_adj & r_phase;

  always_comb begin
    w_div_cnt_d = r_div_cnt;
    w_phase_d   = r_phase;
    if (clr || w_enter_adj) begin
      w_div_cnt_d = '0;
      w_phase_d   = 1'b0;
    end else if (w_tick_adj) begin
      w_div_cnt_d = '0;
      w_phase_d   = ~r_phase;
    end else if (w_ps_run) begin
      w_div_cnt_d = r_div_cnt + CntW'(1);
    end
  end

  // A field switch inside adjust applies to a tick in the same cycle
  assign w_field = (w_in_adj && w_to_adj) ? w_state_d : r_state;

  always_comb begin
    w_sec_inc_d = 1'b0;
    w_min_inc_d = 1'b0;
    unique case (w_field)
      StRun: begin
        w_sec_inc_d = w_tick_1hz;
        w_min_inc_d = w_tick_1hz & sec_at_59;
      end
      StAdjSec: w_sec_inc_d = w_tick_adj;
      StAdjMin: w_min_inc_d = w_tick_adj;
      StPaused: ;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_state   <= StRun;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_pause_q <= 1'b0;
      r_clr     <= 1'b0;
      r_sec_inc <= 1'b0;
      r_min_inc <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_div_cnt <= w_div_cnt_d;
      r_phase   <= w_phase_d;
      r_pause_q <= pause;
      r_clr     <= clr;
      r_sec_inc <= w_sec_inc_d;
      r_min_inc <= w_min_inc_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic r_lap_q, r_disp_hold, w_disp_hold_d;

  always_comb begin
    w_disp_hold_d = r_disp_hold;
    if (clr || ((r_state == StRun) && w_to_adj)) begin
      w_disp_hold_d = 1'b0;
    end else if (lap && !r_lap_q && (r_state == StRun)) begin
      w_disp_hold_d = ~r_disp_hold;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (!reset_n) begin
      r_lap_q     <= 1'b0;
      r_disp_hold <= 1'b0;
    end else begin
      r_lap_q     <= lap;
      r_disp_hold <= w_disp_hold_d;
    end
  end

  assign disp_hold = r_disp_hold;
`else
  assign disp_hold = 1'b0;
`endif

  // Strobes are suppressed for the whole clear window, including the delayed clear
  assign sec_inc   = r_sec_inc & ~clr & ~r_clr;
  assign min_inc   = r_min_inc & ~clr & ~r_clr;
  assign clr_cnt   = r_clr;
  assign blink_sec = (r_state == StAdjSec) & r_phase;
  assign blink_min = (r_state == StAdjMin) & r_phase;
  assign state     = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl (CLK_HZ=8, ADJ_HZ=2): directed sequences, a state table and random traffic
// checked every cycle against a second-counting reference model.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;

  logic       clk;
  logic       reset_n, clr, pause, adj, sel, sec_at_59, lap;
  logic       sec_inc, min_inc, clr_cnt, blink_sec, blink_min, disp_hold;
  logic [1:0] state;

  int n_cmp = 0;
  int n_fail = 0;

  stopwatch_ctrl #(
    .CLK_HZ(8),
    .ADJ_HZ(2)
  ) dut (
    .clk_100MHz(clk),
    .reset_n   (reset_n),
    .clr       (clr),
    .pause     (pause),
    .adj       (adj),
    .sel       (sel),
    .sec_at_59 (sec_at_59),
`ifdef STOPWATCH_LAP_EN
    .lap       (lap),
`endif
    .sec_inc   (sec_inc),
    .min_inc   (min_inc),
    .clr_cnt   (clr_cnt),
    .blink_sec (blink_sec),
    .blink_min (blink_min),
    .state     (state),
    .disp_hold (disp_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Reference model: m_e is the position inside the current one-second window (0..2*DIV-1)
  logic [1:0] m_mode;
  int         m_e;
  bit         m_pprev, m_lprev, m_sec, m_min, m_clrd, m_hold;

  task automatic model_advance();
    bit         pedge, ledge, was_adj, running, t_adj, t_1hz;
    logic [1:0] nxt, fld;
    if (!reset_n) begin
      m_mode = 2'd0; m_e = 0; m_pprev = 0; m_lprev = 0;
      m_sec = 0; m_min = 0; m_clrd = 0; m_hold = 0;
      return;
    end
    pedge   = pause && !m_pprev;
    ledge   = lap && !m_lprev;
    was_adj = (m_mode >= 2'd2);
    if (adj)          nxt = sel ? 2'd3 : 2'd2;
    else if (was_adj) nxt = 2'd1;
    else if (pedge)   nxt = (m_mode == 2'd0) ? 2'd1 : 2'd0;
    else              nxt = m_mode;
    running = (m_mode != 2'd1) && !clr;
    t_adj   = running && ((m_e % DIV) == DIV - 1);
    t_1hz   = t_adj && (m_e == 2 * DIV - 1);
    fld     = (was_adj && nxt >= 2'd2) ? nxt : m_mode;
    m_sec = 0;
    m_min = 0;
    if (fld == 2'd0 && t_1hz) begin
      m_sec = 1;
      m_min = sec_at_59;
    end else if (fld == 2'd3 && t_adj) begin
      m_sec = 1;
    end else if (fld == 2'd2 && t_adj) begin
      m_min = 1;
    end
    if (clr || (nxt >= 2'd2 && !was_adj)) m_e = 0;
    else if (running)                     m_e = (m_e + 1) % (2 * DIV);
    if (clr || (m_mode == 2'd0 && nxt >= 2'd2)) m_hold = 0;
    else if (ledge && m_mode == 2'd0)           m_hold = !m_hold;
    m_clrd  = clr;
    m_pprev = pause;
    m_lprev = lap;
    m_mode  = nxt;
  endtask

  task automatic check_outputs();
    logic [7:0] exp_v, act_v;
    exp_v = {m_mode, m_sec & !clr & !m_clrd, m_min & !clr & !m_clrd, m_clrd,
             (m_mode == 2'd3) && (m_e >= DIV), (m_mode == 2'd2) && (m_e >= DIV), m_hold};
    act_v = {state, sec_inc, min_inc, clr_cnt, blink_sec, blink_min, disp_hold};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL outputs@%0t: got %b expected %b (state,sec,min,clr_cnt,bs,bm,hold)",
               $time, act_v, exp_v);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step();
    model_advance();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic wait_strobe(input bit want_min, input int budget, output int n);
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = want_min ? min_inc : sec_inc;
    end
    if (!seen) n = -1;
  endtask

  typedef struct {
    string      name;
    bit         c, p, a, s, s59;
    int         cycles;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input bit c, input bit p, input bit a, input bit s,
                              input bit s59, input int cyc, input logic [1:0] st);
    vec_t v;
    v.name = nm; v.c = c; v.p = p; v.a = a; v.s = s; v.s59 = s59;
    v.cycles = cyc; v.exp_state = st;
    return v;
  endfunction

  initial begin
    int n, cnt;
    reset_n = 0; clr = 0; pause = 0; adj = 0; sel = 0; sec_at_59 = 0; lap = 0;

    tbl.push_back(mk("run",           0, 0, 0, 0, 0, 10, 2'd0));
    tbl.push_back(mk("pause_hi",      0, 1, 0, 0, 0,  1, 2'd1));
    tbl.push_back(mk("pause_level",   0, 1, 0, 0, 0,  5, 2'd1));
    tbl.push_back(mk("pause_lo",      0, 0, 0, 0, 0,  3, 2'd1));
    tbl.push_back(mk("adj_min",       0, 0, 1, 0, 0,  6, 2'd2));
    tbl.push_back(mk("adj_pause_ign", 0, 1, 1, 0, 0,  3, 2'd2));
    tbl.push_back(mk("adj_sec",       0, 1, 1, 1, 1,  9, 2'd3));
    tbl.push_back(mk("adj_off",       0, 1, 0, 1, 0,  2, 2'd1));
    tbl.push_back(mk("pause_rel",     0, 0, 0, 0, 0,  2, 2'd1));
    tbl.push_back(mk("resume",        0, 1, 0, 0, 0,  1, 2'd0));
    tbl.push_back(mk("clr_run",       1, 1, 0, 0, 0,  3, 2'd0));
    tbl.push_back(mk("run2",          0, 0, 0, 0, 1, 20, 2'd0));
    tbl.push_back(mk("adj_clr",       1, 0, 1, 1, 0,  4, 2'd3));
    tbl.push_back(mk("adj_min2",      0, 0, 1, 0, 1,  7, 2'd2));
    tbl.push_back(mk("exit_adj",      0, 0, 0, 0, 0,  2, 2'd1));

    // Reset and free-running seconds
    repeat (3) step();
    check_int("reset_state", int'(state), 0);
    reset_n = 1;
    wait_strobe(0, 20, n); check_int("first_sec", n, 8);
    wait_strobe(0, 20, n); check_int("sec_period", n, 8);

    // Carry into minutes
    sec_at_59 = 1;
    wait_strobe(0, 20, n); check_int("carry_period", n, 8);
    check_int("carry_min", int'(min_inc), 1);
    step();
    check_int("carry_single", int'(sec_inc | min_inc), 0);
    sec_at_59 = 0;

    // Pause holds the prescaler
    pause = 1; step(); check_int("pause_enter", int'(state), 1);
    pause = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cnt += int'(sec_inc | min_inc);
    end
    check_int("pause_quiet", cnt, 0);
    pause = 1; step(); check_int("pause_exit", int'(state), 0);
    pause = 0;
    wait_strobe(0, 20, n); check_int("resume_phase", n, 6);

    // Adjust mode
    adj = 1; sel = 1; sec_at_59 = 1;
    step(); check_int("adj_sec_enter", int'(state), 3);
    wait_strobe(0, 20, n); check_int("adj_sec_first", n, 4);
    check_int("adj_sec_nocarry", int'(min_inc), 0);
    wait_strobe(0, 20, n); check_int("adj_sec_period", n, 4);
    sel = 0;
    step(); check_int("adj_min_switch", int'(state), 2);
    wait_strobe(1, 20, n); check_int("adj_min_first", n, 3);
    wait_strobe(1, 20, n); check_int("adj_min_period", n, 4);
    adj = 0; sec_at_59 = 0;
    step(); check_int("adj_exit", int'(state), 1);

    // Clear window over a 1 Hz tick
    pause = 1; step(); check_int("clr_pre_run", int'(state), 0);
    pause = 0;
    wait_strobe(0, 20, n); check_int("clr_pre_found", int'(n > 0), 1);
    repeat (6) step();
    clr = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_int("clr_cnt_high", int'(clr_cnt), 1);
      check_int("clr_no_inc", int'(sec_inc), 0);
    end
    clr = 0;
    wait_strobe(0, 20, n); check_int("clr_restart", n, 8);
    check_int("clr_state", int'(state), 0);

    foreach (tbl[k]) begin
      clr = tbl[k].c; pause = tbl[k].p; adj = tbl[k].a; sel = tbl[k].s; sec_at_59 = tbl[k].s59;
      for (int j = 0; j < tbl[k].cycles; j++) step();
      check_int(tbl[k].name, int'(state), int'(tbl[k].exp_state));
    end
    clr = 0; pause = 0; adj = 0; sel = 0; sec_at_59 = 0;

`ifdef STOPWATCH_LAP_EN
    pause = 1; step(); pause = 0; step();
    lap = 1; step(); check_int("lap_on", int'(disp_hold), 1);
    lap = 0;
    wait_strobe(0, 20, n); check_int("lap_counting", int'(n > 0), 1);
    check_int("lap_held", int'(disp_hold), 1);
    lap = 1; step(); check_int("lap_off", int'(disp_hold), 0);
    lap = 0; step();
    lap = 1; step(); lap = 0;
    adj = 1; step(); check_int("lap_adj_clear", int'(disp_hold), 0);
    adj = 0; step();
`endif

    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 499) != 0);
      if (clr) clr = ($urandom_range(0, 2) != 0);
      else     clr = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0)  pause = ~pause;
      if ($urandom_range(0, 39) == 0) adj = ~adj;
      if ($urandom_range(0, 19) == 0) sel = ~sel;
      sec_at_59 = ($urandom_range(0, 3) == 0);
`ifdef STOPWATCH_LAP_EN
      if ($urandom_range(0, 7) == 0) lap = ~lap;
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
